// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer: per-channel 2-flop synchroniser and counter debounce with press/release pulses.
// Define AUTO_REPEAT_EN to build the per-channel hold/auto-repeat pulse train on o_repeat_pulse.
module multi_button_debouncer #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_button,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_pressed_pulse,
  output logic [NUM_CH-1:0] o_released_pulse,
  output logic [NUM_CH-1:0] o_repeat_pulse
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          INV      = (ACTIVE_LOW != 0);

  if (NUM_CH < 1 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("multi_button_debouncer: NUM_CH and all cycle counts must be >= 1");
  end

`ifdef AUTO_REPEAT_EN
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);
`else
  assign o_repeat_pulse = {NUM_CH{1'b0}};
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic          sync_p0;
    logic          sync_p1;
    logic          state_p2;
    logic [CW-1:0] cnt_p2;
    logic          press_p3;
    logic          release_p3;
    logic          accept;

    // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    assign accept = (sync_p1 != state_p2) && (cnt_p2 == CNT_LAST);

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sync_p0    <= 1'b0;
        sync_p1    <= 1'b0;
        state_p2   <= 1'b0;
        cnt_p2     <= '0;
        press_p3   <= 1'b0;
        release_p3 <= 1'b0;
      end else begin
        sync_p0    <= i_button[k] ^ INV;
        sync_p1    <= sync_p0;
        press_p3   <= accept & sync_p1;
        release_p3 <= accept & ~sync_p1;
        if (sync_p1 == state_p2) begin
          cnt_p2 <= '0;
        end else if (accept) begin
          state_p2 <= sync_p1;
          cnt_p2   <= '0;
        end else begin
          cnt_p2 <= cnt_p2 + CW'(1);
        end
      end
    end

    assign o_level[k]          = state_p2;
    assign o_pressed_pulse[k]  = press_p3;
    assign o_released_pulse[k] = release_p3;

`ifdef AUTO_REPEAT_EN
    logic [HW-1:0] hcnt_p3;
    logic [HW-1:0] hnext;
    logic          armed_p3;
    logic          rep_p3;

    assign hnext = hcnt_p3 + HW'(1);

    // armed_p3 selects the repeat interval once the initial hold interval has elapsed.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        hcnt_p3  <= '0;
        armed_p3 <= 1'b0;
        rep_p3   <= 1'b0;
      end else if (!state_p2 || accept) begin
        hcnt_p3  <= '0;
        armed_p3 <= 1'b0;
        rep_p3   <= 1'b0;
      end else if (hnext == (armed_p3 ? HW'(REPEAT_CYCLES) : HW'(HOLD_CYCLES))) begin
        hcnt_p3  <= '0;
        armed_p3 <= 1'b1;
        rep_p3   <= 1'b1;
      end else begin
        hcnt_p3  <= hnext;
        rep_p3   <= 1'b0;
      end
    end

    assign o_repeat_pulse[k] = rep_p3;
`endif
  end
endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer: NUM_CH=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
`timescale 1ns/1ps
module tb_multi_button_debouncer;
  localparam int NUM_CH = 4;
  localparam int DEB    = 4;
  localparam int HOLD   = 20;
  localparam int REP    = 8;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn = 4'b0000;
  logic [3:0]  btn_al = 4'b1111;
  logic [3:0]  lvl, prs, rel, rpt;
  logic [3:0]  al_lvl, al_prs, al_rel, al_rpt;
  logic [15:0] dut_o, al_o;
  int          passes = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  multi_button_debouncer #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .ACTIVE_LOW(0)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_button(btn),
    .o_level(lvl), .o_pressed_pulse(prs), .o_released_pulse(rel), .o_repeat_pulse(rpt)
  );

  multi_button_debouncer #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1)
  ) u_dut_al (
    .i_clk(clk), .i_rst(rst), .i_button(btn_al),
    .o_level(al_lvl), .o_pressed_pulse(al_prs), .o_released_pulse(al_rel), .o_repeat_pulse(al_rpt)
  );

  assign dut_o = {lvl, prs, rel, rpt};
  assign al_o  = {al_lvl, al_prs, al_rel, al_rpt};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pk(logic [3:0] l, logic [3:0] p, logic [3:0] r, logic [3:0] q);
    return {l, p, r, q};
  endfunction

  // Expected repeat bit i cycles after the press-pulse cycle of a continuously held channel.
  function automatic logic rep_at(int i);
    return REP_EN && (i >= HOLD) && (((i - HOLD) % REP) == 0);
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("reset_held", dut_o, 16'h0000);
    rst = 1'b0;
    tick();
    chk("after_reset", dut_o, 16'h0000);

    // Clean press on ch0, long hold, release
    btn = 4'b0001;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("press0_wait", dut_o, 16'h0000);
    end
    tick();
    chk("press0_pulse", dut_o, pk(4'b0001, 4'b0001, 4'b0000, 4'b0000));
    for (int i = 1; i <= 60; i++) begin
      tick();
      chk("hold0", dut_o, pk(4'b0001, 4'b0000, 4'b0000, {3'b000, rep_at(i)}));
    end
    btn = 4'b0000;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("release0_wait", dut_o, pk(4'b0001, 4'b0000, 4'b0000, {3'b000, rep_at(60 + e)}));
    end
    tick();
    chk("release0_pulse", dut_o, pk(4'b0000, 4'b0000, 4'b0001, 4'b0000));
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk("idle_after_release", dut_o, 16'h0000);
    end

    // Bounce rejection on ch1: 1,0,1,1,0,1,1,1,1 then held
    begin
      logic [8:0] bounce;
      bounce = 9'b111101101;
      for (int j = 0; j <= 8; j++) begin
        btn[1] = bounce[j];
        tick();
        chk("bounce1", dut_o, 16'h0000);
      end
    end
    tick();
    chk("bounce1_settle", dut_o, 16'h0000);
    tick();
    chk("bounce1_pulse", dut_o, pk(4'b0010, 4'b0010, 4'b0000, 4'b0000));
    tick();
    chk("bounce1_level", dut_o, pk(4'b0010, 4'b0000, 4'b0000, 4'b0000));

    // Release ch1 and press ch3 together
    btn = 4'b1000;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("swap13_wait", dut_o, pk(4'b0010, 4'b0000, 4'b0000, 4'b0000));
    end
    tick();
    chk("swap13_pulse", dut_o, pk(4'b1000, 4'b1000, 4'b0010, 4'b0000));
    tick();
    chk("swap13_level", dut_o, pk(4'b1000, 4'b0000, 4'b0000, 4'b0000));

    // Simultaneous ch2 press and ch3 release
    btn = 4'b0100;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("simul_wait", dut_o, pk(4'b1000, 4'b0000, 4'b0000, 4'b0000));
    end
    tick();
    chk("simul_pulse", dut_o, pk(4'b0100, 4'b0100, 4'b1000, 4'b0000));
    tick();
    chk("simul_level", dut_o, pk(4'b0100, 4'b0000, 4'b0000, 4'b0000));

    // Reset while ch0 and ch2 are held
    btn = 4'b0101;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("press0b_wait", dut_o, pk(4'b0100, 4'b0000, 4'b0000, 4'b0000));
    end
    tick();
    chk("press0b_pulse", dut_o, pk(4'b0101, 4'b0001, 4'b0000, 4'b0000));
    rst = 1'b1;
    tick();
    chk("mid_reset", dut_o, 16'h0000);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("post_reset_wait", dut_o, 16'h0000);
    end
    tick();
    chk("post_reset_pulse", dut_o, pk(4'b0101, 4'b0101, 4'b0000, 4'b0000));

    // Glitch of DEB-1 samples on held ch0 must be ignored
    btn[0] = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("glitch_low", dut_o, pk(4'b0101, 4'b0000, 4'b0000, 4'b0000));
    end
    btn[0] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("glitch_after", dut_o, pk(4'b0101, 4'b0000, 4'b0000, 4'b0000));
    end

    btn = 4'b0000;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("release02_wait", dut_o, pk(4'b0101, 4'b0000, 4'b0000, 4'b0000));
    end
    tick();
    chk("release02_pulse", dut_o, pk(4'b0000, 4'b0000, 4'b0101, 4'b0000));

    // Active-low instance: pin driven 1 -> 0 is a press
    chk("al_idle", al_o, 16'h0000);
    btn_al = 4'b1110;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("al_wait", al_o, 16'h0000);
    end
    tick();
    chk("al_pulse", al_o, pk(4'b0001, 4'b0001, 4'b0000, 4'b0000));
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk("al_hold", al_o, pk(4'b0001, 4'b0000, 4'b0000, {3'b000, rep_at(i)}));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
